// File: rtl/audio_vad_gate_if.sv
// audio_vad_gate_if: stereo handshake bundle between input FIFO, gate and output FIFO
interface audio_vad_gate_if;
  logic audio_in_available, audio_out_allowed, read_audio_in, write_audio_out;
  logic [31:0] left_channel_audio_in, right_channel_audio_in;
  logic [31:0] left_channel_audio_out, right_channel_audio_out;
  modport master (
    output audio_in_available, audio_out_allowed, left_channel_audio_in, right_channel_audio_in,
    input  read_audio_in, write_audio_out, left_channel_audio_out, right_channel_audio_out
  );
  modport slave (
    input  audio_in_available, audio_out_allowed, left_channel_audio_in, right_channel_audio_in,
    output read_audio_in, write_audio_out, left_channel_audio_out, right_channel_audio_out
  );
endinterface

// File: rtl/audio_vad_gate.sv
// audio_vad_gate: forwards stereo samples, measures frame energy and gates audio by voice activity
module audio_vad_gate #(
  parameter int FRAME_LEN = 256,
  parameter int LOG2_FRAME = 8,
  parameter int ONSET_FRAMES = 2,
  parameter int HANG_FRAMES = 8,
  localparam int ACC_W = 16 + LOG2_FRAME
) (
  input  logic CLOCK_50,
  input  logic reset,
  audio_vad_gate_if.slave bus,
  input  logic gate_en,
  input  logic [15:0] on_thresh,
  input  logic [15:0] off_thresh,
  output logic [ACC_W-1:0] frame_energy,
  output logic [15:0] frame_mean,
  output logic frame_valid,
  output logic vad_active,
  output logic vad_start
);
  localparam int CW = $clog2(ONSET_FRAMES + HANG_FRAMES + 1);
  localparam logic [1:0] IDLE = 2'd0, ONSET = 2'd1, ACTIVE = 2'd2, HANG = 2'd3;
  logic accept, last, mute, loud, quiet;
  logic [15:0] s, mag;
  logic [ACC_W-1:0] acc, sum;
  logic [LOG2_FRAME-1:0] sample_cnt;
  logic [1:0] state, state_nx;
  logic [CW-1:0] cnt, cnt_nx, cnt_inc;
  assign accept = bus.audio_in_available & bus.audio_out_allowed & ~reset;
  assign bus.read_audio_in = accept;
  assign bus.write_audio_out = accept;
  assign mute = gate_en & ~vad_active;
  assign bus.left_channel_audio_out = mute ? '0 : bus.left_channel_audio_in;
  assign bus.right_channel_audio_out = mute ? '0 : bus.right_channel_audio_in;
  assign s = bus.left_channel_audio_in[31:16];
  assign mag = s[15] ? (s == 16'h8000 ? 16'h7fff : ~s + 1'b1) : s;
  assign sum = acc + ACC_W'(mag);
  assign last = &sample_cnt;
  assign loud = frame_mean >= on_thresh;
  assign quiet = frame_mean < off_thresh;
  assign cnt_inc = cnt + 1'b1;
  // next VAD state from the just-completed frame mean; ACTIVE/HANG share bit 1 as the activity flag
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    case (state)
      IDLE: if (loud) begin
        state_nx = ONSET_FRAMES == 1 ? ACTIVE : ONSET;
        cnt_nx = ONSET_FRAMES == 1 ? '0 : CW'(1);
      end
      ONSET: begin
        state_nx = !loud ? IDLE : (cnt_inc == CW'(ONSET_FRAMES) ? ACTIVE : ONSET);
        cnt_nx = (loud && cnt_inc != CW'(ONSET_FRAMES)) ? cnt_inc : '0;
      end
      ACTIVE: if (quiet) begin
        state_nx = HANG;
        cnt_nx = CW'(1);
      end
      default: begin
        state_nx = !quiet ? ACTIVE : (cnt_inc >= CW'(HANG_FRAMES) ? IDLE : HANG);
        cnt_nx = (quiet && cnt_inc < CW'(HANG_FRAMES)) ? cnt_inc : '0;
      end
    endcase
  end
  // frame accumulation and VAD state, advanced once per completed frame
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      acc <= '0;
      sample_cnt <= '0;
      cnt <= '0;
      state <= IDLE;
      frame_energy <= '0;
      frame_mean <= '0;
      frame_valid <= 1'b0;
      vad_active <= 1'b0;
      vad_start <= 1'b0;
    end else begin
      frame_valid <= accept & last;
      if (accept) begin
        acc <= last ? '0 : sum;
        sample_cnt <= sample_cnt + 1'b1;
      end
      if (accept & last) begin
        frame_energy <= sum;
        frame_mean <= sum[ACC_W-1:LOG2_FRAME];
      end
      vad_start <= frame_valid && state_nx == ACTIVE && !state[1];
      if (frame_valid) begin
        state <= state_nx;
        cnt <= cnt_nx;
        vad_active <= state_nx[1];
      end
    end
  end
endmodule

// File: tb/tb_audio_vad_gate.sv
// tb_audio_vad_gate: directed and random checks of audio_vad_gate against a frame-level model
module tb_audio_vad_gate;
  localparam int FL = 4, LF = 2, ON_F = 2, HG_F = 2, AW = 16 + LF;
  logic CLOCK_50 = 1'b0, reset = 1'b1, gate_en = 1'b0;
  logic [15:0] on_thresh = 16'd1000, off_thresh = 16'd800;
  logic [AW-1:0] frame_energy;
  logic [15:0] frame_mean;
  logic frame_valid, vad_active, vad_start;
  audio_vad_gate_if bus();
  audio_vad_gate #(.FRAME_LEN(FL), .LOG2_FRAME(LF), .ONSET_FRAMES(ON_F), .HANG_FRAMES(HG_F)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .bus(bus.slave), .gate_en(gate_en),
    .on_thresh(on_thresh), .off_thresh(off_thresh), .frame_energy(frame_energy),
    .frame_mean(frame_mean), .frame_valid(frame_valid), .vad_active(vad_active), .vad_start(vad_start)
  );
  always #5 CLOCK_50 = ~CLOCK_50;
  int n_pass = 0, n_chk = 0, n_fail = 0, writes = 0;
  int m_n = 0, m_sum = 0, e_energy = 0, e_mean = 0, loud_run = 0, quiet_run = 0;
  bit e_fv = 0, e_act = 0, e_start = 0;
  function automatic int mag_of(logic [15:0] v);
    int x;
    x = int'($signed(v));
    return x < 0 ? (x == -32768 ? 32767 : -x) : x;
  endfunction
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_n = 0; m_sum = 0; e_energy = 0; e_mean = 0; loud_run = 0; quiet_run = 0;
    e_fv = 0; e_act = 0; e_start = 0;
  endtask
  task automatic cyc(bit av, bit al, logic [15:0] l, bit g, bit rs);
    bit acc, mute, nfv;
    logic [31:0] lin, rin;
    lin = {l, 16'($urandom)};
    rin = $urandom;
    bus.audio_in_available = av;
    bus.audio_out_allowed = al;
    bus.left_channel_audio_in = lin;
    bus.right_channel_audio_in = rin;
    gate_en = g;
    reset = rs;
    @(negedge CLOCK_50);
    acc = av & al & ~rs;
    mute = g & ~e_act;
    chk("read", bus.read_audio_in, acc);
    chk("write", bus.write_audio_out, acc);
    chk("left_out", bus.left_channel_audio_out, mute ? 32'd0 : lin);
    chk("right_out", bus.right_channel_audio_out, mute ? 32'd0 : rin);
    chk("frame_valid", frame_valid, e_fv);
    chk("frame_energy", frame_energy, e_energy);
    chk("frame_mean", frame_mean, e_mean);
    chk("vad_active", vad_active, e_act);
    chk("vad_start", vad_start, e_start);
    if (acc) writes++;
    if (rs) model_reset();
    else begin
      e_start = 0;
      if (e_fv) begin
        if (!e_act) begin
          loud_run = e_mean >= int'(on_thresh) ? loud_run + 1 : 0;
          if (loud_run >= ON_F) begin e_act = 1; e_start = 1; loud_run = 0; quiet_run = 0; end
        end else begin
          quiet_run = e_mean < int'(off_thresh) ? quiet_run + 1 : 0;
          if (quiet_run >= HG_F) begin e_act = 0; loud_run = 0; quiet_run = 0; end
        end
      end
      nfv = 0;
      if (acc) begin
        m_sum += mag_of(l);
        m_n++;
        if (m_n == FL) begin
          e_energy = m_sum; e_mean = m_sum >> LF; nfv = 1; m_sum = 0; m_n = 0;
        end
      end
      e_fv = nfv;
    end
    @(posedge CLOCK_50);
    #1;
  endtask
  task automatic frame(int lvl, bit g);
    for (int i = 0; i < FL; i++) cyc(1, 1, i[0] ? 16'(-lvl) : 16'(lvl), g, 0);
    cyc(0, 0, 16'h1234, g, 0);
    cyc(0, 0, 16'h1234, g, 0);
  endtask
  initial begin
    int w0, lvl;
    bit loud, g;
    logic [15:0] e_vals [4];
    cyc(0, 0, 0, 0, 1);
    cyc(1, 1, 16'h4000, 0, 1);
    chk("rst_energy", frame_energy, 0);
    chk("rst_active", vad_active, 0);
    w0 = writes;
    for (int i = 0; i < 12; i++) cyc(1, i[0], 16'h0300, 0, 0);
    chk("pt_writes", writes - w0, 6);
    cyc(0, 0, 0, 0, 1);
    e_vals = '{16'h1000, 16'hF000, 16'h0010, 16'h8000};
    for (int i = 0; i < 4; i++) cyc(1, 1, e_vals[i], 0, 0);
    chk("en_fv", frame_valid, 1);
    chk("en_energy", frame_energy, 40975);
    chk("en_mean", frame_mean, 10243);
    cyc(0, 0, 0, 0, 0);
    chk("en_fv_drop", frame_valid, 0);
    cyc(0, 0, 0, 0, 1);
    frame(2000, 0);
    chk("on_f1", vad_active, 0);
    frame(500, 0);
    frame(2000, 0);
    chk("on_f3", vad_active, 0);
    frame(2000, 0);
    chk("on_f4", vad_active, 1);
    frame(100, 1);
    chk("hg_100", vad_active, 1);
    frame(900, 1);
    frame(100, 1);
    chk("hg_q1", vad_active, 1);
    frame(100, 1);
    chk("hg_q2", vad_active, 0);
    cyc(1, 1, 16'h2222, 1, 0);
    chk("hg_gate", bus.left_channel_audio_out, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 1, 16'h0200, 0, 0);
    cyc(1, 1, 16'h0200, 0, 0);
    for (int i = 0; i < 20; i++) cyc(1, 0, 16'h7000, 0, 0);
    cyc(1, 1, 16'h0200, 0, 0);
    cyc(1, 1, 16'h0200, 0, 0);
    chk("st_energy", frame_energy, 2048);
    cyc(1, 1, 16'h0500, 0, 0);
    cyc(1, 1, 16'h0500, 0, 0);
    cyc(1, 1, 16'h0500, 0, 1);
    chk("rm_fv", frame_valid, 0);
    for (int i = 0; i < 4; i++) cyc(1, 1, 16'h0100, 0, 0);
    chk("rm_energy", frame_energy, 1024);
    chk("rm_active", vad_active, 0);
    loud = 0;
    g = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) loud = ~loud;
      if ($urandom_range(0, 49) == 0) g = ~g;
      lvl = $urandom_range(0, loud ? 3000 : 600);
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 99) == 0 ? 16'h8000 : ($urandom_range(0, 1) ? 16'(-lvl) : 16'(lvl)),
          g, $urandom_range(0, 199) == 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/audio_vad_gate.md
Name: audio_vad_gate

Overview:
- Sits between the Audio_Controller input FIFO and its output FIFO.
- Pops one stereo sample per handshake and forwards it to the output FIFO.
- Computes per-frame mean absolute amplitude of the left channel and runs a voice-activity FSM with onset and hangover hysteresis.
- Optionally mutes the forwarded audio while no voice is detected; frame energy and VAD flags feed the downstream digit-recognition front end.

Parameters:
- FRAME_LEN, 256, samples per frame; power of 2, >=2.
- LOG2_FRAME, 8, log2(FRAME_LEN); must match FRAME_LEN.
- ONSET_FRAMES, 2, consecutive loud frames needed to declare voice; >=1.
- HANG_FRAMES, 8, consecutive quiet frames tolerated before voice ends; >=1.
- Derived: ACC_W = 16 + LOG2_FRAME.

Ports:
- CLOCK_50  in  1  sole clock; all state on its rising edge.
- reset  in  1  synchronous, active-high reset.
- audio_in_available  in  1  input FIFO holds a sample.
- left_channel_audio_in  in  32  left sample; signed audio in [31:16].
- right_channel_audio_in  in  32  right sample.
- read_audio_in  out  1  pops input FIFO.
- audio_out_allowed  in  1  output FIFO has room.
- left_channel_audio_out  out  32  forwarded or muted left sample.
- right_channel_audio_out  out  32  forwarded or muted right sample.
- write_audio_out  out  1  pushes output FIFO.
- gate_en  in  1  1 = mute output while vad_active=0.
- on_thresh  in  16  unsigned mean level to start voice.
- off_thresh  in  16  unsigned mean level below which a frame counts as quiet.
- frame_energy  out  ACC_W  sum of |sample| over last completed frame.
- frame_mean  out  16  frame_energy >> LOG2_FRAME.
- frame_valid  out  1  one-cycle pulse: new frame_energy/frame_mean.
- vad_active  out  1  voice present (ACTIVE or HANG).
- vad_start  out  1  one-cycle pulse on entry to ACTIVE from IDLE/ONSET.

Behaviour:
- Handshake:
  - accept = audio_in_available & audio_out_allowed & ~reset.
  - read_audio_in = write_audio_out = accept, combinational, same cycle.
  - No sample is popped without being pushed, and none is ever dropped or duplicated.
- Output data is combinational from the inputs:
  - When gate_en & ~vad_active, both out channels = 0.
  - Otherwise out = in, unmodified.
  - The mute decision uses the registered vad_active in the accept cycle.
- Magnitude:
  - s = left_channel_audio_in[31:16], signed.
  - mag = |s|, 16-bit unsigned; -32768 saturates to 32767.
- Accumulation:
  - On accept, acc += mag and sample_cnt increments.
  - On the accept where sample_cnt == FRAME_LEN-1:
    - frame_energy <= acc + mag, frame_mean <= (acc + mag) >> LOG2_FRAME.
    - frame_valid <= 1 for exactly one cycle.
    - acc <= 0, sample_cnt <= 0.
  - ACC_W guarantees no overflow.
  - Cycles without accept leave acc and sample_cnt unchanged.
- VAD FSM:
  - States IDLE, ONSET, ACTIVE, HANG. It advances only on the rising edge that ends a frame_valid cycle, using frame_mean (m).
  - IDLE:
    - If m >= on_thresh and ONSET_FRAMES == 1, go to ACTIVE.
    - If m >= on_thresh and ONSET_FRAMES > 1, go to ONSET with cnt = 1.
    - Otherwise stay.
  - ONSET:
    - If m >= on_thresh, cnt += 1; go to ACTIVE when cnt+1 == ONSET_FRAMES.
    - If m < on_thresh, go to IDLE with cnt = 0.
  - ACTIVE: if m < off_thresh, go to HANG with cnt = 1; otherwise stay.
  - HANG:
    - If m >= off_thresh, go to ACTIVE.
    - Otherwise cnt += 1; go to IDLE when cnt == HANG_FRAMES (i.e. after HANG_FRAMES consecutive quiet frames).
  - vad_active is registered; it is 1 in ACTIVE or HANG.
  - vad_start pulses for one cycle in the cycle after the transition into ACTIVE from IDLE or ONSET; HANG->ACTIVE does not pulse.
- Latency: frame_valid is high in cycle N+1, where N is the last-sample accept cycle. vad_active/vad_start change in cycle N+2.
- Reset values: acc, sample_cnt, cnt = 0; state = IDLE; frame_energy = 0; frame_mean = 0; frame_valid = 0; vad_active = 0; vad_start = 0.
- Reset mid-frame discards the partial frame; the next accepted sample starts a fresh frame.
- on_thresh < off_thresh is legal; the FSM applies the rules literally.

Test Plan:
- Pass-through: FRAME_LEN=4, gate_en=0; apply 6 samples with out_allowed toggling -> exactly 6 writes, each out word == in word, read_audio_in == write_audio_out every cycle.
- Energy: FRAME_LEN=4; left [31:16] = 0x1000, 0xF000, 0x0010, 0x8000 -> frame_energy = 4096+4096+16+32767 = 40975, frame_mean = 10243, frame_valid high exactly 1 cycle after the 4th accept.
- Onset: FRAME_LEN=4, ONSET_FRAMES=2, on_thresh=1000; frames with mean 2000, 500, 2000, 2000 -> vad_active rises only after the 4th frame, vad_start single pulse, no pulse after frame 1.
- Hangover and gate: HANG_FRAMES=2, off_thresh=800, gate_en=1; from ACTIVE apply means 100, 900, 100, 100 -> stays active through the 900 frame, drops after the 2nd consecutive quiet frame, then outputs read 0 while input is nonzero.
- Stall: audio_out_allowed=0 for 20 cycles with audio_in_available=1 -> read_audio_in=0, sample_cnt and acc frozen, no frame_valid.
- Reset mid-frame: reset after 2 of 4 samples, then 4 samples of 0x0100 -> frame_energy = 1024; state IDLE; all outputs at reset values during reset.
